// File: rtl/time_dmr_ctrl_pkg.sv
// Shared types and helpers for the time-DMR issue/retry controller.
package time_dmr_ctrl_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REPLAY = 1'b1
    } state_e;

    // Width of a retry counter that must be able to hold max_retries itself.
    function automatic int retry_cnt_width(input int max_retries);
        return (max_retries < 1) ? 1 : $clog2(max_retries + 1);
    endfunction

endpackage

// File: rtl/time_dmr_replay_table.sv
// ID-indexed replay storage: valid bit, payload and retry count per entry,
// with a registered occupancy count.
module time_dmr_replay_table #(
    parameter int DATA_W = 8,
    parameter int ID_W   = 4,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_en,
    input  logic [ID_W-1:0]   alloc_id,
    input  logic [DATA_W-1:0] alloc_data,
    input  logic              free_en,
    input  logic [ID_W-1:0]   free_id,
    input  logic              inc_en,
    input  logic [ID_W-1:0]   inc_id,
    input  logic [ID_W-1:0]   rd_a_id,
    output logic              rd_a_valid,
    input  logic [ID_W-1:0]   rd_b_id,
    output logic              rd_b_valid,
    output logic [DATA_W-1:0] rd_b_data,
    output logic [CNT_W-1:0]  rd_b_cnt,
    output logic [ID_W:0]     inflight
);

    localparam int DEPTH = 1 << ID_W;

    logic [DEPTH-1:0]  vld_q;
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q  [DEPTH];
    logic [ID_W:0]     inflight_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Allocation only targets an empty entry and free/increment only a full one,
    // so the three write ports never collide on the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q      <= '0;
            inflight_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            if (alloc_en) begin
                vld_q[alloc_id] <= 1'b1;
                cnt_q[alloc_id] <= '0;
            end
            if (free_en) begin
                vld_q[free_id] <= 1'b0;
            end
            if (inc_en) begin
                cnt_q[inc_id] <= sat_inc(cnt_q[inc_id]);
            end
            inflight_q <= inflight_q + (ID_W+1)'(alloc_en) - (ID_W+1)'(free_en);
        end
    end

    always_ff @(posedge clk) begin
        if (alloc_en) begin
            data_q[alloc_id] <= alloc_data;
        end
    end

    assign rd_a_valid = vld_q[rd_a_id];
    assign rd_b_valid = vld_q[rd_b_id];
    assign rd_b_data  = data_q[rd_b_id];
    assign rd_b_cnt   = cnt_q[rd_b_id];
    assign inflight   = inflight_q;

endmodule

// File: rtl/time_dmr_retry_ctrl.sv
// Issue/retry scheduler in front of time_DMR_start: tags requests with IDs,
// replays results flagged for retry and forwards everything else downstream.
module time_dmr_retry_ctrl
    import time_dmr_ctrl_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int ID_W        = 4,
    parameter int MAX_RETRIES = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [DATA_W-1:0] issue_data_o,
    output logic [ID_W-1:0]   issue_id_o,
    output logic              issue_valid_o,
    input  logic              issue_ready_i,
    input  logic [DATA_W-1:0] fb_data_i,
    input  logic [ID_W-1:0]   fb_id_i,
    input  logic              fb_needs_retry_i,
    input  logic              fb_valid_i,
    output logic              fb_ready_o,
    output logic [DATA_W-1:0] res_data_o,
    output logic [ID_W-1:0]   res_id_o,
    output logic              res_failed_o,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic              spurious_o,
    output logic [ID_W:0]     inflight_o
);

    localparam int CNT_W = retry_cnt_width(MAX_RETRIES);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRIES);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   next_id_q;
    logic [ID_W-1:0]   replay_id_q;
    logic              retry_take;

    logic              alloc_en, free_en, inc_en;
    logic              slot_busy;
    logic [ID_W-1:0]   rd_b_id;
    logic              rd_b_valid;
    logic [DATA_W-1:0] rd_b_data;
    logic [CNT_W-1:0]  rd_b_cnt;

    // While replaying, the second read port serves the replay payload instead of feedback.
    assign rd_b_id = (state_q == REPLAY) ? replay_id_q : fb_id_i;

    time_dmr_replay_table #(
        .DATA_W (DATA_W),
        .ID_W   (ID_W),
        .CNT_W  (CNT_W)
    ) u_table (
        .clk        (clk_i),
        .rst        (rst_i),
        .alloc_en   (alloc_en),
        .alloc_id   (next_id_q),
        .alloc_data (data_i),
        .free_en    (free_en),
        .free_id    (fb_id_i),
        .inc_en     (inc_en),
        .inc_id     (fb_id_i),
        .rd_a_id    (next_id_q),
        .rd_a_valid (slot_busy),
        .rd_b_id    (rd_b_id),
        .rd_b_valid (rd_b_valid),
        .rd_b_data  (rd_b_data),
        .rd_b_cnt   (rd_b_cnt),
        .inflight   (inflight_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            next_id_q   <= '0;
            replay_id_q <= '0;
        end else begin
            state_q <= state_d;
            if (alloc_en) begin
                next_id_q <= next_id_q + 1'b1;
            end
            if (retry_take) begin
                replay_id_q <= fb_id_i;
            end
        end
    end

    // Outputs are combinational and forced to zero while reset is held.
    always_comb begin
        state_d       = state_q;
        ready_o       = 1'b0;
        issue_valid_o = 1'b0;
        issue_data_o  = '0;
        issue_id_o    = '0;
        fb_ready_o    = 1'b0;
        res_valid_o   = 1'b0;
        res_data_o    = '0;
        res_id_o      = '0;
        res_failed_o  = 1'b0;
        spurious_o    = 1'b0;
        alloc_en      = 1'b0;
        free_en       = 1'b0;
        inc_en        = 1'b0;
        retry_take    = 1'b0;
        if (!rst_i) begin
            case (state_q)
                IDLE: begin
                    issue_valid_o = valid_i & ~slot_busy;
                    issue_data_o  = data_i;
                    issue_id_o    = next_id_q;
                    ready_o       = issue_ready_i & ~slot_busy;
                    alloc_en      = valid_i & issue_ready_i & ~slot_busy;
                    fb_ready_o    = res_ready_i;
                    if (fb_valid_i) begin
                        if (!rd_b_valid) begin
                            fb_ready_o = 1'b1;
                            spurious_o = 1'b1;
                        end else if (fb_needs_retry_i && enable_i && (rd_b_cnt < MAX_CNT)) begin
                            fb_ready_o = 1'b1;
                            inc_en     = 1'b1;
                            retry_take = 1'b1;
                            state_d    = REPLAY;
                        end else begin
                            // A failed result reports the original payload, not the corrupted feedback.
                            res_valid_o  = 1'b1;
                            res_id_o     = fb_id_i;
                            res_data_o   = fb_needs_retry_i ? rd_b_data : fb_data_i;
                            res_failed_o = fb_needs_retry_i;
                            free_en      = res_ready_i;
                        end
                    end
                end
                REPLAY: begin
                    issue_valid_o = 1'b1;
                    issue_data_o  = rd_b_data;
                    issue_id_o    = replay_id_q;
                    if (issue_ready_i) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule
